rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's completion strobe and holds it in a DEPTH-entry circular FIFO until the application logic drains it with a read handshake. It also counts framing errors flagged by the receiver and holds a sticky overflow flag. It runs entirely in the receiver's clock domain, so there is no CDC.

Parameters:
DATA_W, 8, byte width; must match the receiver data output.
DEPTH, 16, FIFO entries; power of two.
ADDR_W, 4, log2(DEPTH).
ERR_W, 8, width of the saturating error counter.

Ports:
clk_9600Hz  in  1  bit-rate clock shared with the UART receiver
rst_n  in  1  synchronous reset, active-low
rx_data  in  DATA_W  received byte; valid while rx_done is high
rx_done  in  1  receiver completion strobe; may stay high for more than one cycle
rx_err  in  1  receiver error flag; level signal
rd_en  in  1  read request
clr_flags  in  1  clears ovf and err_cnt
dout  out  DATA_W  read data; registered
dout_vld  out  1  one-cycle pulse, the cycle after an accepted read
empty  out  1  FIFO holds 0 entries
full  out  1  FIFO holds DEPTH entries
level  out  ADDR_W+1  current occupancy, 0..DEPTH
ovf  out  1  sticky: a byte was dropped because the FIFO was full
err_cnt  out  ERR_W  saturating count of rx_err rising edges

Behaviour:
- Clocking: every register updates on the posedge of clk_9600Hz. While rst_n=0, on the clock edge: wr_ptr=0, rd_ptr=0, level=0, dout=0, dout_vld=0, ovf=0, err_cnt=0, edge-detect history=0. After reset, empty=1 and full=0. A reset in mid-operation discards all stored data.
- Write event (wr_ev): rx_done high this cycle and low the previous cycle, i.e. rising edge against a registered copy. If rx_done is already high out of reset, no write occurs until it falls and rises again.
- Error event: rising edge of rx_err, detected the same way.
- Write, FIFO not full: mem[wr_ptr] <= rx_data; wr_ptr increments and wraps DEPTH-1 -> 0.
- Write, FIFO full, no accepted read in the same cycle: byte dropped, ovf <= 1, pointers unchanged.
- Read accept: rd_en=1 and empty=0. Next cycle dout = mem[rd_ptr] at accept time and dout_vld=1. rd_ptr increments with wrap.
- rd_en while empty: ignored. No dout_vld, dout holds its value.
- Simultaneous write and accepted read:
  - Both happen; level is unchanged.
  - When full, the read frees the slot, so the write is accepted and ovf is not set.
  - When empty, the read is not accepted; there is no fall-through. The write lands and level becomes 1.
- dout holds its last value when no read is accepted. dout_vld is high for exactly one cycle per accepted read.
- level: +1 on accepted write only, -1 on accepted read only, unchanged otherwise. empty = (level==0). full = (level==DEPTH). Both are combinational from level.
- err_cnt: +1 per error event and saturates at 2^ERR_W-1.
- clr_flags=1: ovf <= 0 and err_cnt <= 0.
  - If an overflow occurs in the same cycle, clear wins: ovf=0.
  - If an error event occurs in the same cycle, err_cnt <= 0.
- Latency: a byte written at cycle N can be read-accepted at N+1 and appears on dout at N+2.
- Storage: memory has no reset and is read through the registered dout only.

Decomposition:
- Shared package uart_pkg:
  - DATA_W=8
  - FIFO DEPTH and ADDR_W defaults
  - ERR_W
  - clock-name constant for the 9600 Hz domain
- One sub-module, rise_det: synchronous active-low reset; registers its input and outputs in & ~in_d. Instantiate it twice, once for rx_done and once for rx_err.
- Pointer, level and memory logic stay in rx_byte_fifo.

Test Plan:
- Reset / hold-high: hold rst_n=0 for 2 cycles with rx_done=1 held. Required response: empty=1, level=0, dout=0, ovf=0, err_cnt=0; no write after release until rx_done drops and re-rises.
- Ordered transfer: write 0x41, 0x42, 0x43, each with a 3-cycle rx_done pulse. Required response: level=3, one write per pulse. Then rd_en for 3 cycles gives dout 0x41, 0x42, 0x43 with dout_vld high each following cycle; empty=1 at the end.
- Overflow and clear: write 17 bytes 0x00..0x10 with no reads. Required response: full=1, level=16, ovf=1, byte 0x10 dropped; draining returns 0x00..0x0F. Pulsing clr_flags then gives ovf=0.
- Full with simultaneous read and write: with the FIFO full, assert rd_en in the same cycle as a write of 0xAA. Required response: level stays 16, ovf stays 0. Draining returns 0xAA last, and pointers wrap correctly.
- Empty with simultaneous read and write: with the FIFO empty, rd_en=1 with a write of 0x55. Required response: no dout_vld that cycle, level=1. The next read returns 0x55.
- Error counter: apply 300 rx_err rising edges. Required response: err_cnt=255, saturated. clr_flags coinciding with an error edge gives err_cnt=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path running in the 9600 Hz bit-rate domain.
package uart_pkg;

    localparam int unsigned RX_DATA_W      = 8;
    localparam int unsigned RX_FIFO_DEPTH  = 16;
    localparam int unsigned RX_FIFO_ADDR_W = 4;
    localparam int unsigned RX_ERR_W       = 8;

    localparam string RX_CLK_DOMAIN = "clk_9600Hz";

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector against a registered copy of the input; synchronous active-low reset.
module rise_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q, sig_d;
    logic hist_vld_q, hist_vld_d;

    // A level already high when reset releases is not an edge: the history is only
    // trusted once it has captured one real post-reset sample.
    assign rise_o = sig_i & ~sig_q & hist_vld_q;

    always_comb begin
        sig_d      = sig_i;
        hist_vld_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q      <= 1'b0;
            hist_vld_q <= 1'b0;
        end else begin
            sig_q      <= sig_d;
            hist_vld_q <= hist_vld_d;
        end
    end

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO behind the UART receiver: edge-triggered capture, registered read port,
// sticky overflow flag and saturating framing-error counter.
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = RX_DATA_W,
    parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = RX_FIFO_ADDR_W,
    parameter int unsigned ERR_W  = RX_ERR_W
) (
    input  logic              clk_9600Hz,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    input  logic              rd_en,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              ovf_q, ovf_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic wr_ev, err_ev, rd_acc, wr_acc;

    rise_det u_done_det (
        .clk_i  (clk_9600Hz),
        .rst_ni (rst_n),
        .sig_i  (rx_done),
        .rise_o (wr_ev)
    );

    rise_det u_err_det (
        .clk_i  (clk_9600Hz),
        .rst_ni (rst_n),
        .sig_i  (rx_err),
        .rise_o (err_ev)
    );

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    // A read from a full FIFO frees the slot the coincident write needs.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_ev & (~full | rd_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        dout_d     = dout_q;
        dout_vld_d = rd_acc;
        ovf_d      = ovf_q;
        err_cnt_d  = err_cnt_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        if (wr_acc && !rd_acc) begin
            level_d = level_q + LVL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LVL_W'(1);
        end

        if (clr_flags) begin
            ovf_d     = 1'b0;
            err_cnt_d = '0;
        end else begin
            if (wr_ev && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (err_ev && err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_9600Hz) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage is deliberately unreset; it is only observable through dout.
    always_ff @(posedge clk_9600Hz) begin
        if (rst_n && wr_acc) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed self-checking bench for rx_byte_fifo.
module tb_rx_byte_fifo;
    import uart_pkg::*;

    logic       clk_9600Hz = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       rd_en;
    logic       clr_flags;
    logic [7:0] dout;
    logic       dout_vld;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       ovf;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    rx_byte_fifo dut (
        .clk_9600Hz (clk_9600Hz),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rd_en      (rd_en),
        .clr_flags  (clr_flags),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .ovf        (ovf),
        .err_cnt    (err_cnt)
    );

    always #5 clk_9600Hz = ~clk_9600Hz;

    task automatic tick();
        @(posedge clk_9600Hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rx_done high for 'hi' cycles then low for one; exactly one write edge.
    task automatic wr_byte(input logic [7:0] b, input int hi);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hi) tick();
        rx_done = 1'b0;
        tick();
    endtask

    initial begin
        $display("tb_rx_byte_fifo: domain %s", RX_CLK_DOMAIN);
        rst_n = 1'b0; rx_data = 8'h99; rx_done = 1'b1; rx_err = 1'b0;
        rd_en = 1'b0; clr_flags = 1'b0;
        tick(); tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);

        // rx_done held high across reset release must not write
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("hold_high_level", 32'(level), 32'd0);
        rx_done = 1'b0;
        tick();
        check("hold_fall_level", 32'(level), 32'd0);

        // Ordered transfer with 3-cycle strobes
        wr_byte(8'h41, 3);
        wr_byte(8'h42, 3);
        wr_byte(8'h43, 3);
        check("ord_level", 32'(level), 32'd3);
        rd_en = 1'b1;
        tick();
        check("ord_d0", 32'(dout), 32'h41);
        check("ord_v0", 32'(dout_vld), 32'd1);
        tick();
        check("ord_d1", 32'(dout), 32'h42);
        check("ord_v1", 32'(dout_vld), 32'd1);
        tick();
        check("ord_d2", 32'(dout), 32'h43);
        check("ord_v2", 32'(dout_vld), 32'd1);
        check("ord_empty", 32'(empty), 32'd1);
        // rd_en still high while empty: ignored
        tick();
        check("rd_empty_vld", 32'(dout_vld), 32'd0);
        check("rd_empty_dout", 32'(dout), 32'h43);
        rd_en = 1'b0;

        // Overflow: 17 bytes into 16 slots
        for (int i = 0; i < 17; i++) begin
            wr_byte(8'(i), 1);
            if (i == 15) check("ovf_not_yet", 32'(ovf), 32'd0);
        end
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_flag", 32'(ovf), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("ovf_drain%0d", i), 32'(dout), 32'(i));
        end
        rd_en = 1'b0;
        check("ovf_drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Full with coincident read and write; pointers wrap during this
        for (int i = 0; i < 16; i++) wr_byte(8'hB0 + 8'(i), 1);
        check("frw_full", 32'(full), 32'd1);
        rx_data = 8'hAA; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        check("frw_level", 32'(level), 32'd16);
        check("frw_ovf", 32'(ovf), 32'd0);
        check("frw_dout", 32'(dout), 32'hB0);
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("frw_drain%0d", i), 32'(dout),
                  (i < 15) ? 32'(8'hB1 + 8'(i)) : 32'hAA);
        end
        rd_en = 1'b0;
        check("frw_empty", 32'(empty), 32'd1);

        // Empty with coincident read and write: no fall-through
        tick();
        rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        check("erw_vld", 32'(dout_vld), 32'd0);
        check("erw_level", 32'(level), 32'd1);
        check("erw_dout_hold", 32'(dout), 32'hAA);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("erw_read", 32'(dout), 32'h55);
        check("erw_read_vld", 32'(dout_vld), 32'd1);
        tick();
        check("erw_vld_once", 32'(dout_vld), 32'd0);

        // Overflow coinciding with clr_flags: clear wins
        for (int i = 0; i < 16; i++) wr_byte(8'(i), 1);
        rx_data = 8'hEE; rx_done = 1'b1; clr_flags = 1'b1;
        tick();
        rx_done = 1'b0; clr_flags = 1'b0;
        check("ovf_clr_wins", 32'(ovf), 32'd0);
        check("ovf_clr_level", 32'(level), 32'd16);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            rx_err = 1'b1; tick();
            rx_err = 1'b0; tick();
            if (i == 9) check("err_10", 32'(err_cnt), 32'd10);
        end
        check("err_sat", 32'(err_cnt), 32'd255);
        rx_err = 1'b1; clr_flags = 1'b1;
        tick();
        rx_err = 1'b0; clr_flags = 1'b0;
        check("err_clr_wins", 32'(err_cnt), 32'd0);
        tick();
        rx_err = 1'b1; tick();
        rx_err = 1'b0; tick();
        check("err_after_clr", 32'(err_cnt), 32'd1);

        // Mid-operation reset discards stored data
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
